// File: rtl/switch_event_controller.sv
// Switch event controller: per-port PRESS/RELEASE/LONG(/REPEAT) events into a round-robin fed FIFO.
// Latency: input edge at cycle 0 -> event at FIFO head in cycle 2; REPEAT needs SWITCH_EVENT_REPEAT_EN.
// Backpressure: full FIFO stalls the arbiter, pending slots hold; an event for a busy slot is dropped and sets overflow.

module switch_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A full FIFO still accepts a push in the cycle its head is popped.
  assign pop_vld  = (count != '0);
  assign push_rdy = (count != (AW+1)'(DEPTH)) || pop_rdy;
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module switch_event_controller #(
  parameter longint CLOCK_HZ      = 12_000_000,
  parameter int     PORT_BITS     = 4,
  parameter int     LONG_PRESS_MS = 500,
  parameter int     REPEAT_MS     = 100,
  parameter int     FIFO_DEPTH    = 4,
  localparam int    PW            = (PORT_BITS > 1) ? $clog2(PORT_BITS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PORT_BITS-1:0] sw_in,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [PW-1:0]        event_port,
  output logic [1:0]           event_kind,
  output logic                 overflow,
  input  logic                 overflow_clear
);
  localparam logic [31:0] DIV_MAX = 32'(CLOCK_HZ / 64'd1000 - 64'd1);
  localparam int MAX_MS = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int CW     = $clog2(MAX_MS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_t;
  typedef enum logic [1:0] {K_PRESS, K_RELEASE, K_LONG, K_REPEAT} kind_t;

  logic [31:0]          div_q;
  logic                 tick;
  logic [PORT_BITS-1:0] sw_prev;
  logic [PORT_BITS-1:0] rise;
  logic [PORT_BITS-1:0] fall;
  state_t               state_q [PORT_BITS];
  state_t               state_d [PORT_BITS];
  logic [CW-1:0]        cnt_q   [PORT_BITS];
  logic [CW-1:0]        cnt_d   [PORT_BITS];
  logic [PORT_BITS-1:0] ev_gen;
  kind_t                ev_kind [PORT_BITS];
  logic [PORT_BITS-1:0] slot_vld;
  kind_t                slot_kind [PORT_BITS];
  logic [PW-1:0]        last_q;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        gnt_idx;
  logic                 req_any;
  logic                 push_rdy;
  logic                 grant_fire;
  logic [PORT_BITS-1:0] gnt_mask;
  logic                 drop;
  logic [PW+1:0]        fifo_dat;

  assign tick = (div_q == DIV_MAX);
  assign rise = sw_in & ~sw_prev;
  assign fall = ~sw_in & sw_prev;

  // Loading sw_prev during reset keeps a switch held across reset from looking like a new press.
  always_ff @(posedge clock) begin
    sw_prev <= sw_in;
    if (reset) div_q <= '0;
    else       div_q <= tick ? '0 : div_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < PORT_BITS; i++) begin
      if (reset) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PORT_BITS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ev_gen[i]  = 1'b0;
      ev_kind[i] = K_PRESS;
      if (fall[i]) begin
        // A release in IDLE belongs to a press from before reset and stays silent.
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        ev_gen[i]  = (state_q[i] != ST_IDLE);
        ev_kind[i] = K_RELEASE;
      end else begin
        case (state_q[i])
          ST_IDLE: if (rise[i]) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
            ev_gen[i]  = 1'b1;
          end
          ST_HELD: if (tick) begin
            if (cnt_q[i] == CW'(LONG_PRESS_MS - 1)) begin
              state_d[i] = ST_LONG;
              cnt_d[i]   = '0;
              ev_gen[i]  = 1'b1;
              ev_kind[i] = K_LONG;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          ST_LONG: begin
`ifdef SWITCH_EVENT_REPEAT_EN
            if (tick) begin
              if (cnt_q[i] == CW'(REPEAT_MS - 1)) begin
                cnt_d[i]   = '0;
                ev_gen[i]  = 1'b1;
                ev_kind[i] = K_REPEAT;
              end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
              end
            end
`endif
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Round-robin: walk downward so the nearest port after last_q wins.
  always_comb begin
    req_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = PORT_BITS; k >= 1; k--) begin
      cand = PW'((int'(last_q) + k) % PORT_BITS);
      if (slot_vld[cand]) begin
        req_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant_fire = req_any && push_rdy;
  assign gnt_mask   = grant_fire ? (PORT_BITS'(1) << gnt_idx) : '0;
  assign drop       = |(ev_gen & slot_vld & ~gnt_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_vld <= '0;
      last_q   <= PW'(PORT_BITS - 1);
      overflow <= 1'b0;
      for (int i = 0; i < PORT_BITS; i++) slot_kind[i] <= K_PRESS;
    end else begin
      for (int i = 0; i < PORT_BITS; i++) begin
        if (ev_gen[i] && (!slot_vld[i] || gnt_mask[i])) begin
          slot_vld[i]  <= 1'b1;
          slot_kind[i] <= ev_kind[i];
        end else if (gnt_mask[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
      if (grant_fire) last_q <= gnt_idx;
      overflow <= (overflow && !overflow_clear) || drop;
    end
  end

  switch_event_fifo #(
    .WIDTH (PW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (req_any),
    .push_rdy (push_rdy),
    .push_dat ({gnt_idx, slot_kind[gnt_idx]}),
    .pop_vld  (event_valid),
    .pop_rdy  (event_ready),
    .pop_dat  (fifo_dat)
  );

  assign {event_port, event_kind} = fifo_dat;
endmodule

// File: tb/tb_switch_event_controller.sv
// Bench for switch_event_controller: table-driven edge patterns plus hand sequences,
// with a scoreboard queue of expected events popped as the DUT hands them out.
module tb_switch_event_controller;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_in = 4'b0000;
  logic       event_ready = 1'b1;
  logic       overflow_clear = 1'b0;
  logic       event_valid;
  logic [1:0] event_port;
  logic [1:0] event_kind;
  logic       overflow;

  always #5 clock = ~clock;

  switch_event_controller #(
    .CLOCK_HZ      (1_000_000),
    .PORT_BITS     (4),
    .LONG_PRESS_MS (5),
    .REPEAT_MS     (2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sw_in          (sw_in),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_port     (event_port),
    .event_kind     (event_kind),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  localparam int KP = 0, KR = 1, KL = 2, KT = 3;

  typedef struct packed {
    logic [1:0] port;
    logic [1:0] kind;
  } ev_t;

  typedef struct packed {
    logic [3:0]      sw;
    logic [2:0]      n;
    logic [3:0][1:0] port;
    logic [3:0][1:0] kind;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  vec_t tbl[8];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int p, input int k);
    exp_q.push_back(ev_t'{port: 2'(p), kind: 2'(k)});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive at posedge+1; the edge is seen at the next posedge, head must appear two posedges later.
  task automatic latency_check(input string name);
    @(posedge clock); @(negedge clock);
    check({name, "_cyc1"}, event_valid, 1'b0);
    @(posedge clock); @(negedge clock);
    check({name, "_cyc2"}, event_valid, 1'b1);
  endtask

  always @(negedge clock) begin
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got port %0d kind %0d, want none (t=%0t)",
                 event_port, event_kind, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_port", event_port, mon_e.port);
        check("sb_kind", event_kind, mon_e.kind);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[1] = '{4'b0000, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {2'd1, 2'd1, 2'd1, 2'd1}};
    tbl[2] = '{4'b0101, 3'd2, {2'd0, 2'd0, 2'd2, 2'd0}, {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[3] = '{4'b1010, 3'd4, {2'd2, 2'd1, 2'd0, 2'd3}, {2'd1, 2'd0, 2'd1, 2'd0}};
    tbl[4] = '{4'b1011, 3'd1, {2'd0, 2'd0, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[5] = '{4'b0000, 3'd3, {2'd0, 2'd0, 2'd3, 2'd1}, {2'd1, 2'd1, 2'd1, 2'd1}};
    tbl[6] = '{4'b0100, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}, {2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[7] = '{4'b0000, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}, {2'd0, 2'd0, 2'd0, 2'd1}};

    // Reset state, during and just after reset.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", event_valid, 1'b0);
    check("rst_port", event_port, 2'd0);
    check("rst_kind", event_kind, 2'd0);
    check("rst_overflow", overflow, 1'b0);
    cyc(1);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_valid", event_valid, 1'b0);
    check("post_rst_overflow", overflow, 1'b0);
    cyc(1);

    // Table of edge patterns; first entry is the all-ports-at-once burst.
    for (int s = 0; s < 8; s++) begin
      sw_in = tbl[s].sw;
      for (int j = 0; j < int'(tbl[s].n); j++) push_ev(int'(tbl[s].port[j]), int'(tbl[s].kind[j]));
      latency_check("tbl_lat");
      for (int j = 1; j < int'(tbl[s].n); j++) begin
        @(negedge clock);
        check("tbl_burst", event_valid, 1'b1);
      end
      cyc(12);
      check("tbl_drained", exp_q.size(), 0);
      check("tbl_overflow", overflow, 1'b0);
    end

    // Short 3 ms press on port 2: PRESS and RELEASE only.
    sw_in = 4'b0100;
    push_ev(2, KP);
    latency_check("short_press");
    check("short_press_port", event_port, 2'd2);
    check("short_press_kind", event_kind, 2'(KP));
    cyc(3000);
    sw_in = 4'b0000;
    push_ev(2, KR);
    latency_check("short_release");
    cyc(20);
    check("short_drained", exp_q.size(), 0);

    // 10 ms hold on port 1: LONG after 5 ticks, REPEATs after 7 and 9 when enabled.
    sw_in = 4'b0010;
    push_ev(1, KP);
    push_ev(1, KL);
`ifdef SWITCH_EVENT_REPEAT_EN
    push_ev(1, KT);
    push_ev(1, KT);
`endif
    cyc(10000);
    sw_in = 4'b0000;
    push_ev(1, KR);
    cyc(20);
    check("hold_drained", exp_q.size(), 0);

    // Stalled consumer, six toggles on port 0: four in FIFO, one in slot, one dropped.
    event_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      sw_in[0] = ~sw_in[0];
      if (t < 5) push_ev(0, t % 2);
      cyc(4);
    end
    cyc(4);
    @(negedge clock);
    check("stall_valid", event_valid, 1'b1);
    check("stall_head_port", event_port, 2'd0);
    check("stall_head_kind", event_kind, 2'(KP));
    check("stall_overflow", overflow, 1'b1);
    // New drop in the same cycle as overflow_clear keeps overflow set.
    cyc(1);
    sw_in[0] = 1'b1;
    overflow_clear = 1'b1;
    cyc(1);
    overflow_clear = 1'b0;
    @(negedge clock);
    check("clear_vs_drop", overflow, 1'b1);
    cyc(1);
    event_ready = 1'b1;
    cyc(15);
    check("stall_drained", exp_q.size(), 0);
    check("overflow_sticky", overflow, 1'b1);
    sw_in[0] = 1'b0;
    push_ev(0, KR);
    cyc(10);
    check("stall_release_drained", exp_q.size(), 0);
    overflow_clear = 1'b1;
    cyc(1);
    overflow_clear = 1'b0;
    @(negedge clock);
    check("overflow_cleared", overflow, 1'b0);
    cyc(1);

    // Reset with three queued events and port 3 held: everything discarded.
    event_ready = 1'b0;
    sw_in = 4'b0001;
    cyc(4);
    sw_in = 4'b0000;
    cyc(4);
    sw_in = 4'b1000;
    cyc(4);
    @(negedge clock);
    check("pre_rst_valid", event_valid, 1'b1);
    cyc(1);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("mid_rst_valid", event_valid, 1'b0);
    check("mid_rst_port", event_port, 2'd0);
    check("mid_rst_kind", event_kind, 2'd0);
    cyc(3);
    reset = 1'b0;
    event_ready = 1'b1;
    @(negedge clock);
    check("rel_rst_valid", event_valid, 1'b0);
    cyc(30);
    check("held_no_press", event_valid, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
